// File: rtl/arithmetic_pkg.sv
// Shared definitions for the arithmetic AXI4-Lite slave: register map,
// opcodes, FSM states and STATUS bit positions.
package arithmetic_pkg;

    localparam logic [2:0] REG_OP_A    = 3'd0;
    localparam logic [2:0] REG_OP_B    = 3'd1;
    localparam logic [2:0] REG_CTRL    = 3'd2;
    localparam logic [2:0] REG_SCRATCH = 3'd3;
    localparam logic [2:0] REG_RES_LO  = 3'd4;
    localparam logic [2:0] REG_RES_HI  = 3'd5;
    localparam logic [2:0] REG_STATUS  = 3'd6;

    localparam int NUM_RW_REGS = 4;
    localparam int CTRL_GO_BIT = 31;

    localparam int STATUS_BUSY = 0;
    localparam int STATUS_DONE = 1;
    localparam int STATUS_ERR  = 2;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_ILL = 2'd3
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_MUL  = 2'd2
    } state_e;

    // Byte-lane merge of a write into an existing 32-bit register value.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_value,
                                                input logic [31:0] new_value,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_value;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                merged[8*i +: 8] = new_value[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/arithmetic_seq_mul.sv
// 32x32->64 unsigned shift-add multiplier, one multiplier bit per cycle.
// done is high during the last iteration, when product already holds the final sum.
module arithmetic_seq_mul (
    input  logic        clk,
    input  logic        srst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);

    logic [63:0] mcand_reg;
    logic [63:0] acc_reg;
    logic [63:0] acc_next;
    logic [31:0] mplier_reg;
    logic [4:0]  count_reg;
    logic        busy_reg;

    assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : 64'd0);
    assign busy     = busy_reg;
    assign done     = busy_reg && (count_reg == 5'd31);
    assign product  = acc_next;

    always_ff @(posedge clk) begin
        if (srst) begin
            mcand_reg  <= '0;
            acc_reg    <= '0;
            mplier_reg <= '0;
            count_reg  <= '0;
            busy_reg   <= 1'b0;
        end else if (start) begin
            mcand_reg  <= {32'd0, a};
            acc_reg    <= '0;
            mplier_reg <= b;
            count_reg  <= '0;
            busy_reg   <= 1'b1;
        end else if (busy_reg) begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            count_reg  <= count_reg + 5'd1;
            if (done) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/arithmetic_axil_slave.sv
// AXI4-Lite slave exposing four RW registers and a write-launched
// add/sub/mul engine with 64-bit result and status readback.
module arithmetic_axil_slave
    import arithmetic_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    logic        init_done_reg;
    logic        aw_held_reg;
    logic        w_held_reg;
    logic        bvalid_reg;
    logic [2:0]  aw_idx_reg;
    logic [31:0] w_data_reg;
    logic [3:0]  w_strb_reg;
    logic        rvalid_reg;
    logic [31:0] rdata_reg;
    logic [31:0] rdata_next;
    logic [31:0] rw_q [NUM_RW_REGS];

    state_e      state_reg, state_next;
    opcode_e     opcode_reg;
    opcode_e     launch_op;
    logic [31:0] snap_a_reg, snap_b_reg;
    logic [63:0] result_reg, result_next;
    logic        done_reg, done_next;
    logic        err_reg, err_next;
    logic [31:0] diff;
    logic [31:0] status_word;
    logic [31:0] ctrl_commit;

    logic aw_hs, w_hs, ar_hs, commit, launch;
    logic mul_busy, mul_done;
    logic [63:0] mul_product;
    logic unused_addr_bits;

    // Only ADDR[4:2] decodes; the remaining address bits are intentionally ignored.
    assign unused_addr_bits = ^{S_AXI_AWADDR, S_AXI_ARADDR};

    assign S_AXI_AWREADY = init_done_reg && !aw_held_reg && !bvalid_reg;
    assign S_AXI_WREADY  = init_done_reg && !w_held_reg && !bvalid_reg;
    assign S_AXI_ARREADY = init_done_reg && !rvalid_reg;
    assign S_AXI_BVALID  = bvalid_reg;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_reg;
    assign S_AXI_RDATA   = rdata_reg;
    assign S_AXI_RRESP   = 2'b00;

    assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign commit = aw_held_reg && w_held_reg && !bvalid_reg;

    // Opcode comes from the CTRL value being committed, not the old one.
    assign ctrl_commit = apply_wstrb(rw_q[REG_CTRL[1:0]], w_data_reg, w_strb_reg);
    assign launch_op   = opcode_e'(ctrl_commit[1:0]);
    assign launch      = commit && (aw_idx_reg == REG_CTRL) && w_strb_reg[3]
                         && w_data_reg[CTRL_GO_BIT] && (state_reg == ST_IDLE);

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            init_done_reg <= 1'b0;
            aw_held_reg   <= 1'b0;
            w_held_reg    <= 1'b0;
            aw_idx_reg    <= '0;
            w_data_reg    <= '0;
            w_strb_reg    <= '0;
            bvalid_reg    <= 1'b0;
        end else begin
            init_done_reg <= 1'b1;
            if (aw_hs) begin
                aw_held_reg <= 1'b1;
                aw_idx_reg  <= S_AXI_AWADDR[4:2];
            end
            if (w_hs) begin
                w_held_reg <= 1'b1;
                w_data_reg <= S_AXI_WDATA;
                w_strb_reg <= S_AXI_WSTRB;
            end
            if (commit) begin
                bvalid_reg <= 1'b1;
            end else if (bvalid_reg && S_AXI_BREADY) begin
                bvalid_reg  <= 1'b0;
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_RW_REGS; gi++) begin : gen_rw
        logic [31:0] value_reg;
        always_ff @(posedge S_AXI_ACLK) begin
            if (S_AXI_ARESET) begin
                value_reg <= '0;
            end else if (commit && (aw_idx_reg == 3'(gi))) begin
                value_reg <= apply_wstrb(value_reg, w_data_reg, w_strb_reg);
            end
        end
        assign rw_q[gi] = value_reg;
    end

    always_comb begin
        status_word = '0;
        status_word[STATUS_BUSY] = (state_reg != ST_IDLE);
        status_word[STATUS_DONE] = done_reg;
        status_word[STATUS_ERR]  = err_reg;
    end

    always_comb begin
        rdata_next = '0;
        case (S_AXI_ARADDR[4:2])
            REG_RES_LO: rdata_next = result_reg[31:0];
            REG_RES_HI: rdata_next = result_reg[63:32];
            REG_STATUS: rdata_next = status_word;
            default: begin
                if (!S_AXI_ARADDR[4]) begin
                    rdata_next = rw_q[S_AXI_ARADDR[3:2]];
                end
            end
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
        end else if (ar_hs) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= rdata_next;
        end else if (rvalid_reg && S_AXI_RREADY) begin
            rvalid_reg <= 1'b0;
        end
    end

    // Operands are frozen at launch so later OP_A/OP_B writes cannot disturb a running op.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            snap_a_reg <= '0;
            snap_b_reg <= '0;
            opcode_reg <= OP_ADD;
        end else if (launch) begin
            snap_a_reg <= rw_q[REG_OP_A[1:0]];
            snap_b_reg <= rw_q[REG_OP_B[1:0]];
            opcode_reg <= launch_op;
        end
    end

    arithmetic_seq_mul u_mul (
        .clk     (S_AXI_ACLK),
        .srst    (S_AXI_ARESET),
        .start   (launch && (launch_op == OP_MUL)),
        .a       (rw_q[REG_OP_A[1:0]]),
        .b       (rw_q[REG_OP_B[1:0]]),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state_reg  <= ST_IDLE;
            result_reg <= '0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            result_reg <= result_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
        done_next   = done_reg;
        err_next    = err_reg;
        diff        = snap_a_reg - snap_b_reg;
        case (state_reg)
            ST_IDLE: begin
                if (launch) begin
                    done_next  = 1'b0;
                    err_next   = 1'b0;
                    state_next = (launch_op == OP_MUL) ? ST_MUL : ST_CALC;
                end
            end
            ST_CALC: begin
                state_next = ST_IDLE;
                done_next  = 1'b1;
                case (opcode_reg)
                    OP_ADD:  result_next = {32'd0, snap_a_reg} + {32'd0, snap_b_reg};
                    OP_SUB:  result_next = {{32{diff[31]}}, diff};
                    default: err_next = 1'b1;
                endcase
            end
            ST_MUL: begin
                if (mul_done) begin
                    result_next = mul_product;
                    done_next   = 1'b1;
                    state_next  = ST_IDLE;
                end else if (!mul_busy) begin
                    // Multiplier lost its operation; report an error rather than hang busy.
                    err_next   = 1'b1;
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_arithmetic_axil_slave.sv
// Self-checking bench for arithmetic_axil_slave: read data is checked through
// an expectation queue filled when each read address is issued.
module tb_arithmetic_axil_slave;

    localparam logic [4:0] A_OP_A    = 5'h00;
    localparam logic [4:0] A_OP_B    = 5'h04;
    localparam logic [4:0] A_CTRL    = 5'h08;
    localparam logic [4:0] A_SCRATCH = 5'h0C;
    localparam logic [4:0] A_RES_LO  = 5'h10;
    localparam logic [4:0] A_RES_HI  = 5'h14;
    localparam logic [4:0] A_STATUS  = 5'h18;
    localparam logic [4:0] A_UNUSED  = 5'h1C;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [4:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    arithmetic_axil_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(5)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (rst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    // mode 0: AW and W together, 1: AW first, 2: W first. Returns in the commit cycle.
    task automatic wr_addr_data(input logic [4:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, input int mode);
        bit aw_done = 0, w_done = 0, aw_acc, w_acc;
        int guard = 0;
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        awvalid = (mode != 2);
        wvalid  = (mode != 1);
        while (!(aw_done && w_done) && guard < 20) begin
            aw_acc = awvalid && awready;
            w_acc  = wvalid && wready;
            tick();
            guard++;
            if (aw_acc) begin aw_done = 1; awvalid = 1'b0; end
            if (w_acc)  begin w_done = 1;  wvalid  = 1'b0; end
            if (mode == 1 && aw_done && !w_done) wvalid = 1'b1;
            if (mode == 2 && w_done && !aw_done) awvalid = 1'b1;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        n_checks++;
        if (!(aw_done && w_done)) begin
            n_fail++;
            $display("FAIL wr_handshake addr=%h: aw_done=%0d w_done=%0d required 1 1", addr, aw_done, w_done);
        end
        n_checks++;
        if (bvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL bvalid_early addr=%h: bvalid=%b required 0 in commit cycle", addr, bvalid);
        end
        $display("wr addr=%h data=%h strb=%b mode=%0d cyc=%0d", addr, data, strb, mode, cyc);
    endtask

    task automatic wr_resp(input string name);
        tick();
        n_checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            n_fail++;
            $display("FAIL %s_bresp: bvalid=%b bresp=%b required 1 00", name, bvalid, bresp);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        n_checks++;
        if (bvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_bclear: bvalid=%b required 0", name, bvalid);
        end
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int mode, input string name);
        wr_addr_data(addr, data, strb, mode);
        wr_resp(name);
    endtask

    task automatic rd_issue(input logic [4:0] addr, input logic [31:0] expv);
        int guard = 0;
        while (arready !== 1'b1 && guard < 20) begin tick(); guard++; end
        n_checks++;
        if (arready !== 1'b1) begin
            n_fail++;
            $display("FAIL arready_wait addr=%h: arready=%b required 1", addr, arready);
        end
        exp_q.push_back(expv);
        araddr  = addr;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
    endtask

    task automatic rd_collect(input string name);
        int guard = 0;
        logic [31:0] expv;
        while (rvalid !== 1'b1 && guard < 50) begin tick(); guard++; end
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
        n_checks++;
        if (rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: rvalid never rose, expected data %h", name, expv);
        end else if (rdata !== expv || rresp !== 2'b00) begin
            n_fail++;
            $display("FAIL %s: rdata=%h rresp=%b required %h 00", name, rdata, rresp, expv);
        end
        $display("rd %-14s data=%h exp=%h cyc=%0d", name, rdata, expv, cyc);
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] addr, input logic [31:0] expv, input string name);
        rd_issue(addr, expv);
        rd_collect(name);
    endtask

    // Launch via CTRL; STATUS is sampled in cycle T+probe_at (1 or 2).
    task automatic launch(input logic [31:0] ctrl, input int probe_at,
                          input logic [31:0] exp_status, output int t_commit);
        wr_addr_data(A_CTRL, ctrl, 4'hF, 0);
        t_commit = cyc;
        tick();
        n_checks++;
        if (bvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL launch_bvalid: bvalid=%b required 1 at T+1", bvalid);
        end
        bready = 1'b1;
        if (probe_at == 1) begin
            exp_q.push_back(exp_status);
            araddr  = A_STATUS;
            arvalid = 1'b1;
        end
        tick();
        bready  = 1'b0;
        arvalid = 1'b0;
        if (probe_at == 2) begin
            exp_q.push_back(exp_status);
            araddr  = A_STATUS;
            arvalid = 1'b1;
            tick();
            arvalid = 1'b0;
        end
        rd_collect("status_probe");
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0 || rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy/valid=%b rdata=%h required 00000 0",
                     {awready, wready, arready, bvalid, rvalid}, rdata);
        end
        rst = 1'b0;
        n_checks++;
        if ({awready, wready, arready} !== 3'b000) begin
            n_fail++;
            $display("FAIL ready_first_cycle: ready=%b required 000", {awready, wready, arready});
        end
        tick();
        n_checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            n_fail++;
            $display("FAIL ready_after_reset: ready=%b required 111", {awready, wready, arready});
        end
        for (int i = 0; i < 8; i++) axi_read(5'(i * 4), 32'd0, "reset_value");
    endtask

    task automatic test_rw_basic();
        for (int i = 0; i < 4; i++) axi_write(5'(i * 4), 32'(i + 1), 4'hF, 0, "rw_basic");
        for (int i = 0; i < 4; i++) axi_read(5'(i * 4), 32'(i + 1), "rw_basic");
    endtask

    task automatic test_write_order();
        axi_write(A_OP_A, 32'h1111_1111, 4'hF, 1, "aw_first");
        axi_write(A_OP_B, 32'h2222_2222, 4'hF, 2, "w_first");
        axi_write(A_SCRATCH, 32'h3333_3333, 4'hF, 0, "same_cycle");
        axi_read(A_OP_A, 32'h1111_1111, "aw_first");
        axi_read(A_OP_B, 32'h2222_2222, "w_first");
        axi_read(A_SCRATCH, 32'h3333_3333, "same_cycle");
    endtask

    task automatic test_wstrb_ro();
        axi_write(A_SCRATCH, 32'hAABB_CCDD, 4'hF, 0, "scratch_full");
        axi_write(A_SCRATCH, 32'h1122_3344, 4'b0101, 0, "scratch_strb");
        axi_read(A_SCRATCH, 32'hAA22_CC44, "scratch_strb");
        axi_write(A_RES_LO, 32'hDEAD_BEEF, 4'hF, 0, "ro_res_lo");
        axi_write(A_STATUS, 32'hFFFF_FFFF, 4'hF, 0, "ro_status");
        axi_read(A_RES_LO, 32'd0, "ro_res_lo");
        axi_read(A_STATUS, 32'd0, "ro_status");
        axi_read(A_UNUSED, 32'd0, "addr_1c");
    endtask

    task automatic test_add();
        int t;
        axi_write(A_OP_A, 32'hFFFF_FFFF, 4'hF, 0, "add_a");
        axi_write(A_OP_B, 32'h0000_0001, 4'hF, 0, "add_b");
        launch(32'h8000_0000, 2, 32'h2, t);
        axi_read(A_RES_HI, 32'h0000_0001, "add_res_hi");
        axi_read(A_RES_LO, 32'h0000_0000, "add_res_lo");
    endtask

    task automatic test_sub();
        int t;
        axi_write(A_OP_A, 32'd5, 4'hF, 0, "sub_a");
        axi_write(A_OP_B, 32'd7, 4'hF, 0, "sub_b");
        launch(32'h8000_0001, 1, 32'h1, t);
        axi_read(A_STATUS, 32'h2, "sub_status");
        axi_read(A_RES_HI, 32'hFFFF_FFFF, "sub_res_hi");
        axi_read(A_RES_LO, 32'hFFFF_FFFE, "sub_res_lo");
    endtask

    task automatic test_illegal();
        int t;
        launch(32'h8000_0003, 2, 32'h6, t);
        axi_read(A_RES_HI, 32'hFFFF_FFFF, "ill_res_hi");
        axi_read(A_RES_LO, 32'hFFFF_FFFE, "ill_res_lo");
    endtask

    task automatic test_mul();
        int t;
        axi_write(A_OP_A, 32'hFFFF_FFFF, 4'hF, 0, "mul_a");
        axi_write(A_OP_B, 32'hFFFF_FFFF, 4'hF, 0, "mul_b");
        launch(32'h8000_0002, 2, 32'h1, t);
        wait_until(t + 9);
        wr_addr_data(A_CTRL, 32'h8000_0001, 4'hF, 0);
        wr_resp("mul_relaunch");
        axi_write(A_OP_A, 32'd3, 4'hF, 0, "mul_midop_a");
        wait_until(t + 16);
        axi_read(A_STATUS, 32'h1, "mul_busy_t16");
        wait_until(t + 31);
        axi_read(A_STATUS, 32'h1, "mul_busy_t31");
        wait_until(t + 33);
        axi_read(A_STATUS, 32'h2, "mul_done_t33");
        axi_read(A_RES_LO, 32'h0000_0001, "mul_res_lo");
        axi_read(A_RES_HI, 32'hFFFF_FFFE, "mul_res_hi");
        axi_read(A_CTRL, 32'h8000_0001, "mul_ctrl_store");
        axi_read(A_STATUS, 32'h2, "mul_no_relaunch");
    endtask

    task automatic test_backpressure();
        wr_addr_data(A_SCRATCH, 32'h5A5A_5A5A, 4'hF, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
                n_fail++;
                $display("FAIL b_hold: bvalid=%b bresp=%b awready=%b wready=%b required 1 00 0 0",
                         bvalid, bresp, awready, wready);
            end
        end
        wr_resp("b_hold");
        rd_issue(A_SCRATCH, 32'h5A5A_5A5A);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (rvalid !== 1'b1 || rdata !== 32'h5A5A_5A5A || arready !== 1'b0) begin
                n_fail++;
                $display("FAIL r_hold: rvalid=%b rdata=%h arready=%b required 1 5a5a5a5a 0",
                         rvalid, rdata, arready);
            end
            tick();
        end
        rd_collect("r_hold");
    endtask

    task automatic test_reset_mid_mul();
        int t;
        launch(32'h8000_0002, 2, 32'h1, t);
        wr_addr_data(A_SCRATCH, 32'h0BAD_F00D, 4'hF, 0);
        tick();
        araddr  = A_OP_A;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        rst = 1'b1;
        tick();
        n_checks++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b0 || bresp !== 2'b00
            || rdata !== 32'd0 || rresp !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid_mul: rdy/valid=%b rdata=%h required 00000 00000000",
                     {awready, wready, bvalid, arready, rvalid}, rdata);
        end
        rst = 1'b0;
        tick();
        axi_read(A_STATUS, 32'd0, "rst_status");
        axi_read(A_OP_A, 32'd0, "rst_op_a");
        axi_read(A_SCRATCH, 32'd0, "rst_scratch");
        repeat (40) tick();
        axi_read(A_STATUS, 32'd0, "rst_status_late");
        axi_read(A_RES_LO, 32'd0, "rst_res_lo");
        axi_read(A_RES_HI, 32'd0, "rst_res_hi");
    endtask

    initial begin
        rst     = 1'b1;
        awaddr  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        araddr  = '0;
        arvalid = 1'b0;
        rready  = 1'b0;
        test_reset();
        test_rw_basic();
        test_write_order();
        test_wstrb_ro();
        test_add();
        test_sub();
        test_illegal();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
